// File: rtl/sargantana_icache_mem_array_pkg.sv
// Shared types and limits for the Sargantana icache storage slice.
package sargantana_icache_mem_pkg;

   localparam int MAX_WAYS     = 8;
   localparam int READ_LAT_MAX = 2;

   // Tag width carried by one tag/valid entry; the top-level TAG_W follows it.
   localparam int ENTRY_TAG_W  = 20;

   // Controller-facing walker states: INIT after reset, FLUSH on request.
   typedef enum logic [1:0] {
      INIT,
      IDLE,
      FLUSH
   } state_t;

   // One tag-array word: valid bit above the tag.
   typedef struct packed {
      logic                   vbit;
      logic [ENTRY_TAG_W-1:0] tag;
   } tag_entry_t;

endpackage

// File: rtl/sargantana_icache_mem_array_if.sv
// Request/response bundle between the icache controller and the storage array.
interface sargantana_icache_mem_array_if #(
   parameter int N_WAY      = 4,
   parameter int SET_ADDR_W = 6,
   parameter int LINE_W     = 256,
   parameter int TAG_W      = 20
);
   logic                    req_i;
   logic                    we_i;
   logic [N_WAY-1:0]        way_i;
   logic [SET_ADDR_W-1:0]   addr_i;
   logic [TAG_W-1:0]        tag_i;
   logic [LINE_W-1:0]       line_i;
   logic                    vbit_i;
   logic                    flush_i;
   logic                    ready_o;
   logic                    busy_o;
   logic                    flush_done_o;
   logic                    rvalid_o;
   logic [N_WAY*TAG_W-1:0]  tag_way_o;
   logic [N_WAY*LINE_W-1:0] line_way_o;
   logic [N_WAY-1:0]        vbit_o;
   logic [N_WAY-1:0]        hit_way_o;
   logic                    hit_o;

   modport master (
      output req_i, we_i, way_i, addr_i, tag_i, line_i, vbit_i, flush_i,
      input  ready_o, busy_o, flush_done_o, rvalid_o, tag_way_o, line_way_o,
             vbit_o, hit_way_o, hit_o
   );

   modport slave (
      input  req_i, we_i, way_i, addr_i, tag_i, line_i, vbit_i, flush_i,
      output ready_o, busy_o, flush_done_o, rvalid_o, tag_way_o, line_way_o,
             vbit_o, hit_way_o, hit_o
   );
endinterface

// File: rtl/sargantana_icache_way_bank.sv
// One cache way: single-port tag/valid array and line array with a registered read.
module sargantana_icache_way_bank
   import sargantana_icache_mem_pkg::*;
#(
   parameter int N_SETS     = 64,
   parameter int SET_ADDR_W = $clog2(N_SETS),
   parameter int LINE_W     = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  i_tag_we,
   input  logic                  i_line_we,
   input  logic                  i_re,
   input  logic [SET_ADDR_W-1:0] i_addr,
   input  tag_entry_t            i_entry,
   input  logic [LINE_W-1:0]     i_line,
   output tag_entry_t            o_entry,
   output logic [LINE_W-1:0]     o_line
);
   tag_entry_t        r_tag_mem  [N_SETS];
   logic [LINE_W-1:0] r_line_mem [N_SETS];
   tag_entry_t        r_rd_entry;
   logic [LINE_W-1:0] r_rd_line;

   // Array writes; tag and line have separate enables so walks leave data alone.
   // NOTE: storage arrays get no reset; the tag walker clears valid bits instead.
   always_ff @(posedge clk_i) begin
      if (i_tag_we)  r_tag_mem[i_addr]  <= i_entry;
      if (i_line_we) r_line_mem[i_addr] <= i_line;
   end

   // Registered read port; holds its value between reads.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_entry <= '0;
         r_rd_line  <= '0;
      end else if (i_re) begin
         r_rd_entry <= r_tag_mem[i_addr];
         r_rd_line  <= r_line_mem[i_addr];
      end
   end

   assign o_entry = r_rd_entry;
   assign o_line  = r_rd_line;

endmodule

// File: rtl/sargantana_icache_mem_array.sv
// Icache storage top: walker FSM, N-way banks, read pipeline and tag compare.
module sargantana_icache_mem_array
   import sargantana_icache_mem_pkg::*;
#(
   parameter int N_WAY      = 4,
   parameter int N_SETS     = 64,
   parameter int SET_ADDR_W = $clog2(N_SETS),
   parameter int LINE_W     = 256,
   parameter int TAG_W      = ENTRY_TAG_W,
   parameter int READ_LAT   = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   sargantana_icache_mem_array_if.slave bus
);
   state_t                  r_state;
   logic [SET_ADDR_W-1:0]   r_cnt;
   logic                    r_flush_done;
   logic                    r_valid1;
   logic [TAG_W-1:0]        r_lookup_tag;

   logic                    w_walk;
   logic                    w_accept;
   logic                    w_rd;
   logic                    w_wr;
   logic [SET_ADDR_W-1:0]   w_addr;
   tag_entry_t              w_wentry;
   tag_entry_t              w_rentry [N_WAY];
   logic [LINE_W-1:0]       w_rline  [N_WAY];
   logic [N_WAY-1:0]        w_hit1;
   logic [N_WAY-1:0]        w_vbit1;
   logic [N_WAY*TAG_W-1:0]  w_tag1;
   logic [N_WAY*LINE_W-1:0] w_line1;

   assign w_walk           = (r_state != IDLE);
   assign bus.ready_o      = (r_state == IDLE) && !bus.flush_i;
   assign bus.busy_o       = w_walk;
   assign bus.flush_done_o = r_flush_done;
   assign w_accept         = bus.req_i && bus.ready_o;
   assign w_rd             = w_accept && !bus.we_i;
   assign w_wr             = w_accept && bus.we_i;
   // The walker owns the single array port whenever it is active.
   assign w_addr           = w_walk ? r_cnt : bus.addr_i;
   assign w_wentry         = w_walk ? '0 : tag_entry_t'{vbit: bus.vbit_i, tag: bus.tag_i};

   // Walker FSM: clear every set after reset or a flush, then serve requests.
   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= INIT;
         r_cnt        <= '0;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            INIT, FLUSH: begin
               if (&r_cnt) begin
                  r_state      <= IDLE;
                  r_cnt        <= '0;
                  r_flush_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            IDLE:    if (bus.flush_i) r_state <= FLUSH;
            default: r_state <= INIT;
         endcase
      end
   end

   for (genvar g = 0; g < N_WAY; g++) begin : g_way
      sargantana_icache_way_bank #(
         .N_SETS     (N_SETS),
         .SET_ADDR_W (SET_ADDR_W),
         .LINE_W     (LINE_W)
      ) u_bank (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .i_tag_we  (w_walk | (w_wr & bus.way_i[g])),
         .i_line_we (w_wr & bus.way_i[g]),
         .i_re      (w_rd),
         .i_addr    (w_addr),
         .i_entry   (w_wentry),
         .i_line    (bus.line_i),
         .o_entry   (w_rentry[g]),
         .o_line    (w_rline[g])
      );

      assign w_vbit1[g]                   = w_rentry[g].vbit;
      assign w_hit1[g]                    = w_rentry[g].vbit && (w_rentry[g].tag == r_lookup_tag);
      assign w_tag1[g*TAG_W +: TAG_W]     = w_rentry[g].tag;
      assign w_line1[g*LINE_W +: LINE_W]  = w_rline[g];
   end

   // First read stage: valid flag and lookup tag, aligned with the bank read registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid1     <= 1'b0;
         r_lookup_tag <= '0;
      end else begin
         r_valid1 <= w_rd;
         if (w_rd) r_lookup_tag <= bus.tag_i;
      end
   end

   if (READ_LAT >= READ_LAT_MAX) begin : g_lat2
      logic                    r_valid2;
      logic [N_WAY*TAG_W-1:0]  r_tag2;
      logic [N_WAY*LINE_W-1:0] r_line2;
      logic [N_WAY-1:0]        r_vbit2;
      logic [N_WAY-1:0]        r_hit2;

      // Optional output stage; only loads on a valid read so outputs hold otherwise.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_valid2 <= 1'b0;
            r_tag2   <= '0;
            r_line2  <= '0;
            r_vbit2  <= '0;
            r_hit2   <= '0;
         end else begin
            r_valid2 <= r_valid1;
            if (r_valid1) begin
               r_tag2  <= w_tag1;
               r_line2 <= w_line1;
               r_vbit2 <= w_vbit1;
               r_hit2  <= w_hit1;
            end
         end
      end

      assign bus.rvalid_o   = r_valid2;
      assign bus.tag_way_o  = r_tag2;
      assign bus.line_way_o = r_line2;
      assign bus.vbit_o     = r_vbit2;
      assign bus.hit_way_o  = r_hit2;
   end else begin : g_lat1
      assign bus.rvalid_o   = r_valid1;
      assign bus.tag_way_o  = w_tag1;
      assign bus.line_way_o = w_line1;
      assign bus.vbit_o     = w_vbit1;
      assign bus.hit_way_o  = w_hit1;
   end

   // Multiple hits are passed through untouched.
   assign bus.hit_o = |bus.hit_way_o;

endmodule

// File: tb/tb_sargantana_icache_mem_array.sv
// Self-checking bench: one stimulus stream drives a READ_LAT=1 and a READ_LAT=2 instance.
module tb_sargantana_icache_mem_array;
   localparam int N_WAY = 4, N_SETS = 64, SET_ADDR_W = 6, LINE_W = 256, TAG_W = 20;

   typedef struct {
      bit                    we;
      logic [N_WAY-1:0]      way;
      logic [SET_ADDR_W-1:0] addr;
      logic [TAG_W-1:0]      tag;
      logic [LINE_W-1:0]     line;
      bit                    vb;
      logic [N_WAY-1:0]      exp_hw;
      logic [N_WAY-1:0]      exp_vb;
   } vec_t;

   typedef struct {
      logic [N_WAY-1:0][TAG_W-1:0]  tags;
      logic [N_WAY-1:0][LINE_W-1:0] lines;
      logic [N_WAY-1:0]             lmask;
      logic [N_WAY-1:0]             vb;
      logic [N_WAY-1:0]             hw;
      int                           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req = 1'b0, we = 1'b0, vbit = 1'b0, flush = 1'b0;
   logic [N_WAY-1:0]      way  = '0;
   logic [SET_ADDR_W-1:0] addr = '0;
   logic [TAG_W-1:0]      tag  = '0;
   logic [LINE_W-1:0]     line = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [TAG_W-1:0]  m_tag   [N_WAY][N_SETS];
   bit                m_v     [N_WAY][N_SETS];
   logic [LINE_W-1:0] m_line  [N_WAY][N_SETS];
   bit                m_known [N_WAY][N_SETS];

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   vec_t vecs [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sargantana_icache_mem_array_if #(.N_WAY(N_WAY), .SET_ADDR_W(SET_ADDR_W), .LINE_W(LINE_W), .TAG_W(TAG_W)) if1 ();
   sargantana_icache_mem_array_if #(.N_WAY(N_WAY), .SET_ADDR_W(SET_ADDR_W), .LINE_W(LINE_W), .TAG_W(TAG_W)) if2 ();

   assign if1.req_i = req;   assign if2.req_i = req;
   assign if1.we_i = we;     assign if2.we_i = we;
   assign if1.way_i = way;   assign if2.way_i = way;
   assign if1.addr_i = addr; assign if2.addr_i = addr;
   assign if1.tag_i = tag;   assign if2.tag_i = tag;
   assign if1.line_i = line; assign if2.line_i = line;
   assign if1.vbit_i = vbit; assign if2.vbit_i = vbit;
   assign if1.flush_i = flush; assign if2.flush_i = flush;

   sargantana_icache_mem_array #(.N_WAY(N_WAY), .N_SETS(N_SETS), .LINE_W(LINE_W), .TAG_W(TAG_W), .READ_LAT(1))
      dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
   sargantana_icache_mem_array #(.N_WAY(N_WAY), .N_SETS(N_SETS), .LINE_W(LINE_W), .TAG_W(TAG_W), .READ_LAT(2))
      dut2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic compare_resp(input string dn, input exp_t e, input logic [N_WAY*TAG_W-1:0] tw,
                               input logic [N_WAY*LINE_W-1:0] lw, input logic [N_WAY-1:0] vb,
                               input logic [N_WAY-1:0] hw, input logic h);
      check({dn, "_vbit"}, 256'(vb), 256'(e.vb));
      check({dn, "_hit_way"}, 256'(hw), 256'(e.hw));
      check({dn, "_hit"}, 256'(h), 256'(|e.hw));
      for (int i = 0; i < N_WAY; i++) begin
         check($sformatf("%s_tag_w%0d", dn, i), 256'(tw[i*TAG_W +: TAG_W]), 256'(e.tags[i]));
         if (e.lmask[i]) check($sformatf("%s_line_w%0d", dn, i), lw[i*LINE_W +: LINE_W], e.lines[i]);
      end
   endtask

   // Scoreboard for the 1-cycle instance: an entry is due exactly at its cycle.
   always @(negedge clk) begin
      if (!rst) begin
         automatic bit due = (q1.size() != 0) && (q1[0].cyc == cyc);
         if (if1.rvalid_o || due) check("lat1_rvalid", 256'(if1.rvalid_o), 256'(due));
         if (due) begin
            e1 = q1.pop_front();
            if (if1.rvalid_o)
               compare_resp("lat1", e1, if1.tag_way_o, if1.line_way_o, if1.vbit_o, if1.hit_way_o, if1.hit_o);
         end
      end
   end

   // Scoreboard for the 2-cycle instance.
   always @(negedge clk) begin
      if (!rst) begin
         automatic bit due = (q2.size() != 0) && (q2[0].cyc == cyc);
         if (if2.rvalid_o || due) check("lat2_rvalid", 256'(if2.rvalid_o), 256'(due));
         if (due) begin
            e2 = q2.pop_front();
            if (if2.rvalid_o)
               compare_resp("lat2", e2, if2.tag_way_o, if2.line_way_o, if2.vbit_o, if2.hit_way_o, if2.hit_o);
         end
      end
   end

   // One request in one cycle; called at posedge+1, returns at the next posedge+1.
   task automatic do_op(input vec_t v);
      exp_t e;
      req = 1'b1; we = v.we; way = v.way; addr = v.addr; tag = v.tag; line = v.line; vbit = v.vb;
      if (v.we) begin
         for (int i = 0; i < N_WAY; i++) begin
            if (v.way[i]) begin
               m_tag[i][v.addr] = v.tag; m_v[i][v.addr] = v.vb;
               m_line[i][v.addr] = v.line; m_known[i][v.addr] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N_WAY; i++) begin
            e.tags[i] = m_tag[i][v.addr]; e.lines[i] = m_line[i][v.addr]; e.lmask[i] = m_known[i][v.addr];
         end
         e.vb = v.exp_vb; e.hw = v.exp_hw;
         e.cyc = cyc + 1; q1.push_back(e);
         e.cyc = cyc + 2; q2.push_back(e);
      end
      @(negedge clk);
      check("ready_at_req", 256'(if1.ready_o), 256'(1));
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0; way = '0;
   endtask

   task automatic start_flush(input bit with_req);
      flush = 1'b1; req = with_req; we = 1'b0; addr = 6'd5; tag = 20'hABCDE;
      for (int i = 0; i < N_WAY; i++)
         for (int s = 0; s < N_SETS; s++) begin m_tag[i][s] = '0; m_v[i][s] = 1'b0; end
      @(negedge clk);
      check("flush_ready_low", 256'(if1.ready_o), 256'(0));
      @(posedge clk); #1;
      flush = 1'b0; req = 1'b0;
   endtask

   // Counts busy cycles until flush_done; optionally re-pulses flush mid-walk.
   task automatic wait_walk(input string nm, input int pulse_at);
      int busy_cnt = 0;
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (i == pulse_at) flush = 1'b1;
         else if (i == pulse_at + 1) flush = 1'b0;
         if (if1.flush_done_o) done = 1'b1;
         else if (if1.busy_o) busy_cnt++;
      end
      flush = 1'b0;
      check({nm, "_done_seen"}, 256'(done), 256'(1));
      check({nm, "_walk_cycles"}, 256'(busy_cnt), 256'(N_SETS));
      check({nm, "_ready_after"}, 256'(if1.ready_o), 256'(1));
      check({nm, "_busy_after"}, 256'(if1.busy_o), 256'(0));
      check({nm, "_lat2_done"}, 256'(if2.flush_done_o), 256'(1));
      @(negedge clk);
      check({nm, "_done_single"}, 256'(if1.flush_done_o), 256'(0));
      @(posedge clk); #1;
   endtask

   task automatic check_reset(input string nm);
      check({nm, "_ready"}, 256'({if2.ready_o, if1.ready_o}), 256'(0));
      check({nm, "_busy"}, 256'({if2.busy_o, if1.busy_o}), 256'(3));
      check({nm, "_flush_done"}, 256'({if2.flush_done_o, if1.flush_done_o}), 256'(0));
      check({nm, "_rvalid"}, 256'({if2.rvalid_o, if1.rvalid_o}), 256'(0));
      check({nm, "_hit"}, 256'({if2.hit_o, if1.hit_o}), 256'(0));
      check({nm, "_hit_way"}, 256'({if2.hit_way_o, if1.hit_way_o}), 256'(0));
      check({nm, "_vbit"}, 256'({if2.vbit_o, if1.vbit_o}), 256'(0));
      check({nm, "_tag_way"}, 256'({if2.tag_way_o, if1.tag_way_o}), 256'(0));
      for (int i = 0; i < N_WAY; i++) begin
         check($sformatf("%s_line1_w%0d", nm, i), if1.line_way_o[i*LINE_W +: LINE_W], 256'(0));
         check($sformatf("%s_line2_w%0d", nm, i), if2.line_way_o[i*LINE_W +: LINE_W], 256'(0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < N_WAY; i++)
         for (int s = 0; s < N_SETS; s++) begin
            m_tag[i][s] = '0; m_v[i][s] = 1'b0; m_line[i][s] = '0; m_known[i][s] = 1'b0;
         end

      //           we    way      addr    tag          line           vb    exp_hw   exp_vb
      vecs[0]  = '{1'b1, 4'b0100, 6'd5,  20'hABCDE, 256'h1234, 1'b1, 4'b0000, 4'b0000};
      vecs[1]  = '{1'b0, 4'b0000, 6'd5,  20'hABCDE, 256'h0,    1'b0, 4'b0100, 4'b0100};
      vecs[2]  = '{1'b0, 4'b0000, 6'd5,  20'hABCDF, 256'h0,    1'b0, 4'b0000, 4'b0100};
      vecs[3]  = '{1'b1, 4'b0011, 6'd1,  20'h11111, 256'hAAAA, 1'b1, 4'b0000, 4'b0000};
      vecs[4]  = '{1'b1, 4'b1000, 6'd2,  20'h22222, 256'hBBBB, 1'b1, 4'b0000, 4'b0000};
      vecs[5]  = '{1'b1, 4'b0001, 6'd3,  20'h33333, 256'hCCCC, 1'b0, 4'b0000, 4'b0000};
      vecs[6]  = '{1'b0, 4'b0000, 6'd1,  20'h11111, 256'h0,    1'b0, 4'b0011, 4'b0011};
      vecs[7]  = '{1'b0, 4'b0000, 6'd2,  20'h22222, 256'h0,    1'b0, 4'b1000, 4'b1000};
      vecs[8]  = '{1'b0, 4'b0000, 6'd3,  20'h33333, 256'h0,    1'b0, 4'b0000, 4'b0000};
      vecs[9]  = '{1'b1, 4'b0000, 6'd4,  20'h44444, 256'h4444, 1'b1, 4'b0000, 4'b0000};
      vecs[10] = '{1'b0, 4'b0000, 6'd4,  20'h44444, 256'h0,    1'b0, 4'b0000, 4'b0000};
      vecs[11] = '{1'b1, 4'b0010, 6'd7,  20'h77777, 256'hDDDD, 1'b1, 4'b0000, 4'b0000};
      vecs[12] = '{1'b0, 4'b0000, 6'd7,  20'h77777, 256'h0,    1'b0, 4'b0010, 4'b0010};
      vecs[13] = '{1'b1, 4'b1111, 6'd63, 20'hFFFFF, 256'hEE,   1'b1, 4'b0000, 4'b0000};
      vecs[14] = '{1'b0, 4'b0000, 6'd63, 20'hFFFFF, 256'h0,    1'b0, 4'b1111, 4'b1111};
      vecs[15] = '{1'b0, 4'b0000, 6'd0,  20'h00000, 256'h0,    1'b0, 4'b0000, 4'b0000};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      wait_walk("init_walk", -1);

      do_op('{1'b0, 4'b0000, 6'd5, 20'hABCDE, 256'h0, 1'b0, 4'b0000, 4'b0000});
      for (int i = 0; i < 16; i++) do_op(vecs[i]);

      // Flush with a simultaneous request while the last reads are still in flight.
      start_flush(1'b1);
      wait_walk("flush_walk", -1);
      do_op('{1'b0, 4'b0000, 6'd5, 20'hABCDE, 256'h0, 1'b0, 4'b0000, 4'b0000});

      // A second flush pulse at walk cycle 10 must not restart the walk.
      start_flush(1'b0);
      wait_walk("reflush_ignored", 10);

      do_op('{1'b1, 4'b0001, 6'd9, 20'h99999, 256'h9999, 1'b1, 4'b0000, 4'b0000});
      do_op('{1'b0, 4'b0000, 6'd9, 20'h99999, 256'h0, 1'b0, 4'b0001, 4'b0001});
      repeat (4) @(posedge clk);
      #1;

      // Reset in the middle of a walk clears outputs at once and restarts the walk.
      start_flush(1'b0);
      repeat (30) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset("midwalk_reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_walk("reset_walk", -1);
      do_op('{1'b0, 4'b0000, 6'd9, 20'h99999, 256'h0, 1'b0, 4'b0000, 4'b0000});

      repeat (5) @(posedge clk);
      #1;
      check("lat1_queue_drained", 256'(q1.size()), 256'(0));
      check("lat2_queue_drained", 256'(q2.size()), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
